stw_result_collector: RTL and testbench

- Upstream neighbour of the per-column proxy controllers.
- After a stationary-test-weight (STW) pass has loaded a known weight and input into the systolic array, this block scans PE outputs row by row and compares each against the expected product.
- It builds the per-column pass/fail matrix and raises completion, which feed the proxy controllers' STW_result_mat and STW_complete inputs.
- Result bit = 1 means the PE passed; 0 means the PE is faulty.

---
 rtl/stw_result_collector.sv | 111 +++++++++++
 tb/tb_stw_result_collector.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/stw_result_collector.sv
// stw_result_collector: scans the rows of PE outputs after a stationary-test-weight pass and builds the pass/fail matrix.
//
// Optional feature macro: STICKY_FAULT_EN
//   defined   : an accepted start keeps the matrix and faults accumulate across passes (only reset restores all ones)
//   undefined : an accepted start reinitialises the matrix to all ones
//
// Ports:
//   i_clk              clock, rising edge
//   i_rst              synchronous active-low reset
//   i_stall            freezes the whole block, including the compare pipeline
//   i_start            single-cycle scan request (accepted only in IDLE and when not stalled)
//   i_test_weight      signed STW weight of this pass
//   i_test_input       signed STW left input of this pass
//   o_rd_en            readback request for row o_rd_row_sel
//   o_rd_row_sel       row being read back
//   i_pe_out           requested row's PE outputs, column c at [c*WORD_SIZE +: WORD_SIZE], valid 1 cycle after o_rd_en
//   o_stw_result_mat   pass bits, column c / row r at [c*ROWS + r]
//   o_stw_complete     scan finished, results valid
//   o_busy             scan in progress
//   o_fault_any        registered OR of all inverted result bits
module stw_result_collector #(
   parameter int ROWS      = 4,
   parameter int COLS      = 4,
   parameter int WORD_SIZE = 16,
   localparam int RW       = ROWS > 1 ? $clog2(ROWS) : 1
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_stall,
   input  logic                      i_start,
   input  logic [WORD_SIZE-1:0]      i_test_weight,
   input  logic [WORD_SIZE-1:0]      i_test_input,
   output logic                      o_rd_en,
   output logic [RW-1:0]             o_rd_row_sel,
   input  logic [COLS*WORD_SIZE-1:0] i_pe_out,
   output logic [COLS*ROWS-1:0]      o_stw_result_mat,
   output logic                      o_stw_complete,
   output logic                      o_busy,
   output logic                      o_fault_any
);
`ifdef STICKY_FAULT_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
   state_t                 r_state, w_next;
   logic [RW-1:0]          r_row, r_row_d;
   logic                   r_rd_en_d, r_complete, r_fault;
   logic [WORD_SIZE-1:0]   r_exp, w_exp;
   logic [COLS*ROWS-1:0]   r_mat, w_sel, w_match, w_keep;
   logic                   w_accept, w_last;
   // The low WORD_SIZE bits of a product are identical for signed and unsigned
   // operands, so the truncated full-width signed product needs no wider multiply.
   assign w_exp = i_test_weight * i_test_input;
   always_comb begin
      w_accept     = (r_state == IDLE) && i_start && !i_stall;
      w_last       = r_row == RW'(ROWS - 1);
      w_next       = r_state;
      o_rd_en      = (r_state == SCAN) && !i_stall;
      o_rd_row_sel = (r_state == SCAN) ? r_row : '0;
      o_busy       = r_state != IDLE;
      case (r_state)
         IDLE:    w_next = w_accept ? SCAN : IDLE;
         SCAN:    w_next = w_last ? DRAIN : SCAN;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge i_clk) begin
      if (!i_rst) r_state <= IDLE;
      else if (!i_stall) r_state <= w_next;
   end
   // Per-bit compare enables: only the bits of the row read back one cycle earlier are written.
   for (genvar c = 0; c < COLS; c++) begin : g_col
      for (genvar r = 0; r < ROWS; r++) begin : g_row
         assign w_match[c*ROWS+r] = i_pe_out[c*WORD_SIZE +: WORD_SIZE] == r_exp;
         assign w_sel[c*ROWS+r]   = r_rd_en_d && (r_row_d == RW'(r));
      end
   end
   // Non-sticky: selected bits are forced open then cleared on mismatch (bit <= match).
   // Sticky: selected bits can only be cleared (bit <= bit & match).
   assign w_keep = STICKY ? r_mat : (r_mat | w_sel);
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_row      <= '0;
         r_row_d    <= '0;
         r_rd_en_d  <= 1'b0;
         r_exp      <= '0;
         r_mat      <= '1;
         r_complete <= 1'b0;
      end else if (!i_stall) begin
         r_rd_en_d <= o_rd_en;
         r_row_d   <= r_row;
         r_mat     <= (w_accept && !STICKY) ? '1 : (w_keep & ~(w_sel & ~w_match));
         if (w_accept) begin
            r_exp      <= w_exp;
            r_row      <= '0;
            r_complete <= 1'b0;
         end
         if (r_state == SCAN) r_row <= w_last ? '0 : r_row + 1'b1;
         if (r_state == DRAIN) r_complete <= 1'b1;
      end
   end
   always_ff @(posedge i_clk) begin
      if (!i_rst) r_fault <= 1'b0;
      else r_fault <= ~&r_mat;
   end
   assign o_stw_result_mat = r_mat;
   assign o_stw_complete   = r_complete;
   assign o_fault_any      = r_fault;
endmodule

// File: tb/tb_stw_result_collector.sv
// tb_stw_result_collector: directed checks of the STW result collector scan, compare, stall, reset and sticky behaviour.
module tb_stw_result_collector;
   localparam int R = 4;
   localparam int C = 4;
   localparam int W = 16;
   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           stall = 1'b0;
   logic           start = 1'b0;
   logic [W-1:0]   test_weight = '0;
   logic [W-1:0]   test_input = '0;
   logic           rd_en;
   logic [1:0]     rd_row_sel;
   logic [C*W-1:0] pe_out = '0;
   logic [C*R-1:0] mat;
   logic           complete, busy, fault_any;
   logic [W-1:0]   pe_mem [R][C];
   int             n_cmp = 0;
   int             n_err = 0;

   stw_result_collector #(.ROWS(R), .COLS(C), .WORD_SIZE(W)) dut (
      .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_start(start),
      .i_test_weight(test_weight), .i_test_input(test_input),
      .o_rd_en(rd_en), .o_rd_row_sel(rd_row_sel), .i_pe_out(pe_out),
      .o_stw_result_mat(mat), .o_stw_complete(complete), .o_busy(busy),
      .o_fault_any(fault_any)
   );

   always #5 clk = ~clk;

   // PE array model: returns the requested row one cycle after rd_en, holds otherwise.
   always @(posedge clk) begin
      if (rd_en) for (int c = 0; c < C; c++) pe_out[c*W +: W] <= pe_mem[rd_row_sel][c];
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input logic [W-1:0] v);
      for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) pe_mem[r][c] = v;
   endtask

   task automatic do_reset;
      rst = 1'b0; start = 1'b0; stall = 1'b0;
      tick; tick;
      rst = 1'b1;
   endtask

   // Leaves the bench 1 time unit after the accepting edge (cycle 1 of the scan).
   task automatic start_pass(input logic [W-1:0] w, input logic [W-1:0] x);
      test_weight = w; test_input = x; start = 1'b1;
      tick;
      start = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0; start = 1'b1; test_weight = 16'd7; test_input = 16'd9;
      tick;
      n_cmp++; if ({busy, rd_en, complete, fault_any} !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {busy, rd_en, complete, fault_any}); end
      n_cmp++; if (mat !== 16'hFFFF) begin n_err++; $display("FAIL reset_mat: got %h want ffff", mat); end
      n_cmp++; if (rd_row_sel !== 2'd0) begin n_err++; $display("FAIL reset_row: got %0d want 0", rd_row_sel); end
      start = 1'b0; rst = 1'b1;
   endtask

   task automatic test_clean;
      do_reset; fill(16'd15);
      start_pass(16'd3, 16'd5);
      for (int i = 0; i < R; i++) begin
         n_cmp++; if ({rd_en, rd_row_sel} !== {1'b1, 2'(i)}) begin n_err++; $display("FAIL clean_rd%0d: got en=%b row=%0d want en=1 row=%0d", i, rd_en, rd_row_sel, i); end
         tick;
      end
      n_cmp++; if ({rd_en, busy, complete} !== 3'b010) begin n_err++; $display("FAIL clean_drain: got en/busy/cmp=%b want 010", {rd_en, busy, complete}); end
      tick;
      n_cmp++; if ({busy, complete} !== 2'b01) begin n_err++; $display("FAIL clean_done: got busy/cmp=%b want 01", {busy, complete}); end
      n_cmp++; if (mat !== 16'hFFFF) begin n_err++; $display("FAIL clean_mat: got %h want ffff", mat); end
      tick;
      n_cmp++; if (fault_any !== 1'b0) begin n_err++; $display("FAIL clean_fault: got %b want 0", fault_any); end
   endtask

   task automatic test_single_fault;
      do_reset; fill(16'd15); pe_mem[1][2] = 16'd14;
      start_pass(16'd3, 16'd5);
      test_weight = 16'd7;
      repeat (R + 1) tick;
      n_cmp++; if (complete !== 1'b1) begin n_err++; $display("FAIL fault_cmp: got %b want 1", complete); end
      n_cmp++; if (mat !== 16'hFDFF) begin n_err++; $display("FAIL fault_mat: got %h want fdff", mat); end
      tick;
      n_cmp++; if (fault_any !== 1'b1) begin n_err++; $display("FAIL fault_any: got %b want 1", fault_any); end
   endtask

   task automatic test_signed;
      do_reset; fill(16'hA070);
      for (int r = 0; r < R; r++) pe_mem[r][0] = 16'h8000;
      start_pass(16'hFED4, 16'd300);
      repeat (R + 1) tick;
      n_cmp++; if (mat !== 16'hFFF0) begin n_err++; $display("FAIL signed_mat: got %h want fff0", mat); end
   endtask

   task automatic test_stall;
      do_reset;
      stall = 1'b1; start = 1'b1; test_weight = 16'd3; test_input = 16'd5;
      tick;
      start = 1'b0; stall = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stall_start: got busy=%b want 0", busy); end
      fill(16'd15); pe_mem[1][2] = 16'd14; pe_mem[3][0] = 16'd0;
      start_pass(16'd3, 16'd5);
      n_cmp++; if ({rd_en, rd_row_sel} !== 3'b100) begin n_err++; $display("FAIL stall_r0: got %b want 100", {rd_en, rd_row_sel}); end
      tick;
      stall = 1'b1; #1;
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if ({rd_en, rd_row_sel, busy} !== 4'b0011) begin n_err++; $display("FAIL stall_hold%0d: got en/row/busy=%b want 0011", i, {rd_en, rd_row_sel, busy}); end
         if (i < 2) tick;
      end
      tick;
      stall = 1'b0; #1;
      for (int i = 1; i < R; i++) begin
         n_cmp++; if ({rd_en, rd_row_sel} !== {1'b1, 2'(i)}) begin n_err++; $display("FAIL stall_rd%0d: got en=%b row=%0d want en=1 row=%0d", i, rd_en, rd_row_sel, i); end
         tick;
      end
      n_cmp++; if (complete !== 1'b0) begin n_err++; $display("FAIL stall_early: got %b want 0", complete); end
      tick;
      n_cmp++; if (complete !== 1'b1) begin n_err++; $display("FAIL stall_cmp: got %b want 1", complete); end
      n_cmp++; if (mat !== 16'hFDF7) begin n_err++; $display("FAIL stall_mat: got %h want fdf7", mat); end
   endtask

   task automatic test_reset_restart;
      do_reset; fill(16'd15); pe_mem[0][0] = 16'd0;
      start_pass(16'd3, 16'd5);
      tick; tick;
      n_cmp++; if ({busy, mat} !== {1'b1, 16'hFFFE}) begin n_err++; $display("FAIL rr_mid: got busy=%b mat=%h want 1 fffe", busy, mat); end
      rst = 1'b0;
      tick;
      rst = 1'b1;
      n_cmp++; if ({busy, complete, rd_en, mat} !== {3'b000, 16'hFFFF}) begin n_err++; $display("FAIL rr_abort: got b/c/e=%b mat=%h want 000 ffff", {busy, complete, rd_en}, mat); end
      fill(16'd15);
      start_pass(16'd3, 16'd5);
      tick;
      start = 1'b1;
      tick;
      start = 1'b0;
      n_cmp++; if ({rd_en, rd_row_sel} !== 3'b110) begin n_err++; $display("FAIL rr_busy_start: got %b want 110", {rd_en, rd_row_sel}); end
      tick; tick; tick;
      n_cmp++; if ({busy, complete} !== 2'b01) begin n_err++; $display("FAIL rr_done1: got busy/cmp=%b want 01", {busy, complete}); end
      tick;
      n_cmp++; if (complete !== 1'b1) begin n_err++; $display("FAIL rr_hold: got %b want 1", complete); end
      start_pass(16'd3, 16'd5);
      n_cmp++; if ({busy, complete} !== 2'b10) begin n_err++; $display("FAIL rr_clear: got busy/cmp=%b want 10", {busy, complete}); end
      repeat (R + 1) tick;
      n_cmp++; if ({busy, complete} !== 2'b01) begin n_err++; $display("FAIL rr_done2: got busy/cmp=%b want 01", {busy, complete}); end
   endtask

   task automatic test_sticky;
      logic [C*R-1:0] want;
`ifdef STICKY_FAULT_EN
      want = 16'hFFDE;
`else
      want = 16'hFFDF;
`endif
      do_reset; fill(16'd15); pe_mem[0][0] = 16'd1;
      start_pass(16'd3, 16'd5);
      repeat (R + 1) tick;
      n_cmp++; if (mat !== 16'hFFFE) begin n_err++; $display("FAIL sticky_p1: got %h want fffe", mat); end
      fill(16'd15); pe_mem[1][1] = 16'd1;
      start_pass(16'd3, 16'd5);
      repeat (R + 1) tick;
      n_cmp++; if (mat !== want) begin n_err++; $display("FAIL sticky_p2: got %h want %h", mat, want); end
   endtask

   initial begin
      fill(16'd0);
      test_reset;
      test_clean;
      test_single_fault;
      test_signed;
      test_stall;
      test_reset_restart;
      test_sticky;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
